scan_beta_store: RTL and testbench

- Parametrised layered storage for the partial-sum (beta) messages of the SCAN polar decoder. Generalises the fixed 1024/256 beta RAM.
- N, P, Q and the layer count are parameters. Each layer holds N/2 values of Q bits.
- Layers whose blocks exceed the datapath are accessed in multi-beat mode.
- Read data is returned with a valid strobe. A per-layer clear engine zeroes a layer between decoding iterations.
- Sits between the SCAN processing elements (writer) and the beta-combine/decision stage (reader).

---
 rtl/scan_beta_store.sv | 196 +++++++++++++++++++
 tb/tb_scan_beta_store.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_beta_store.sv
// scan_beta_store: layered partial-sum (beta) storage for a SCAN polar decoder.
// Layer l (1..LOGN-1) holds N/2 values of Q bits, organised as D = N/(2*2^l)
// blocks of S = 2^l elements. Blocks wider than the datapath are written and
// read in several beats. A clear engine zeroes one block per cycle.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   w_en/w_layer/w_addr/w_beat    write request; w_data = {right half, left half}
//   r_en/r_layer/r_addr/r_beat    read request; r_data/r_vld one cycle later
//   clr_req/clr_layer             start clearing a layer; busy while clearing
//   err                           sticky illegal-access flag
//
// state | meaning
// IDLE  | normal read/write service, accepts clear requests
// CLEAR | zeroing one block of clr_l per cycle, all requests rejected
module scan_beta_store #(
    parameter int P  = 256,
    parameter int Q  = 6,
    parameter int N  = 1024,
    parameter int LW = $clog2($clog2(N)),
    parameter int AW = $clog2(N / 4),
    parameter int BW = ($clog2(N / (2 * P)) < 1) ? 1 : $clog2(N / (2 * P))
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_en,
    input  logic [LW-1:0]      w_layer,
    input  logic [AW-1:0]      w_addr,
    input  logic [BW-1:0]      w_beat,
    input  logic [2*P*Q-1:0]   w_data,
    input  logic               r_en,
    input  logic [LW-1:0]      r_layer,
    input  logic [AW-1:0]      r_addr,
    input  logic [BW-1:0]      r_beat,
    output logic [P*Q-1:0]     r_data,
    output logic               r_vld,
    input  logic               clr_req,
    input  logic [LW-1:0]      clr_layer,
    output logic               busy,
    output logic               err
);

    localparam int LOGN = $clog2(N);
    localparam int HALF = N / 2;
    localparam int EW   = $clog2(HALF);

    typedef enum logic {IDLE, CLEAR} state_t;

    // Layer geometry helpers.
    function automatic int blk_size(int l);
        return 1 << l;
    endfunction

    function automatic int blocks(int l);
        return N >> (l + 1);
    endfunction

    function automatic int wbeats(int l);
        return (blk_size(l) / (2 * P) > 1) ? blk_size(l) / (2 * P) : 1;
    endfunction

    function automatic int rbeats(int l);
        return (blk_size(l) / P > 1) ? blk_size(l) / P : 1;
    endfunction

    function automatic int wv(int l);
        return (blk_size(l) / 2 < P) ? blk_size(l) / 2 : P;
    endfunction

    function automatic int rv(int l);
        return (blk_size(l) < P) ? blk_size(l) : P;
    endfunction

    function automatic logic layer_ok(int l);
        return (l >= 1) && (l <= LOGN - 1);
    endfunction

    // Element j of layer l: which write beat carries it, and where in w_data.
    function automatic int wr_beat(int l, int j);
        int e;
        e = j % blk_size(l);
        return (e % (blk_size(l) / 2)) / wv(l);
    endfunction

    function automatic int wr_bit(int l, int j);
        int e;
        int h;
        e = j % blk_size(l);
        h = e % (blk_size(l) / 2);
        return ((e >= blk_size(l) / 2) ? P * Q : 0) + (h % wv(l)) * Q;
    endfunction

    function automatic logic [EW-1:0] rd_idx(int l, int a, int b, int i);
        int t;
        t = a * blk_size(l) + b * rv(l) + i;
        return EW'(t);
    endfunction

    logic [Q-1:0]  mem [1:LOGN-1][HALF];
    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic [LW-1:0] clr_l, clr_l_nxt;
    logic          w_legal, r_legal, clr_legal;
    logic          w_go, r_go, clearing;
    logic [P*Q-1:0] rd_next;

    assign w_legal = layer_ok(int'(w_layer))
                   && (int'(w_addr) < blocks(int'(w_layer)))
                   && (int'(w_beat) < wbeats(int'(w_layer)));
    assign r_legal = layer_ok(int'(r_layer))
                   && (int'(r_addr) < blocks(int'(r_layer)))
                   && (int'(r_beat) < rbeats(int'(r_layer)));
    assign clr_legal = layer_ok(int'(clr_layer));

    assign clearing = (state == CLEAR);
    assign w_go     = !clearing && w_en && w_legal;
    assign r_go     = !clearing && r_en && r_legal;
    assign busy     = clearing;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            clr_l <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            clr_l <= clr_l_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_l_nxt = clr_l;
        case (state)
            IDLE: begin
                if (clr_req && clr_legal) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                    clr_l_nxt = clr_layer;
                end
            end
            CLEAR: begin
                if (int'(cnt) == blocks(int'(clr_l)) - 1)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt + 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Each element has fixed (block, beat, lane) coordinates per layer, so the
    // loops unroll into plain per-element enables.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 1; l < LOGN; l++)
                for (int j = 0; j < HALF; j++)
                    mem[l][j] <= '0;
        end else begin
            for (int l = 1; l < LOGN; l++)
                for (int j = 0; j < HALF; j++) begin
                    if (clearing && clr_l == LW'(l) && cnt == AW'(j >> l))
                        mem[l][j] <= '0;
                    else if (w_go && w_layer == LW'(l) && w_addr == AW'(j >> l)
                             && w_beat == BW'(wr_beat(l, j)))
                        mem[l][j] <= w_data[wr_bit(l, j) +: Q];
                end
        end
    end

    always_comb begin
        rd_next = '0;
        for (int l = 1; l < LOGN; l++)
            if (r_layer == LW'(l))
                for (int i = 0; i < P; i++)
                    if (i < rv(l))
                        rd_next[i*Q +: Q] = mem[l][rd_idx(l, int'(r_addr), int'(r_beat), i)];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_vld  <= 1'b0;
            err    <= 1'b0;
        end else begin
            r_data <= r_go ? rd_next : '0;
            r_vld  <= r_go;
            if (clearing ? (w_en || r_en || clr_req)
                         : ((w_en && !w_legal) || (r_en && !r_legal) || (clr_req && !clr_legal)))
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_scan_beta_store.sv
module tb_scan_beta_store;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_en;
    logic [2:0]  w_layer;
    logic [2:0]  w_addr;
    logic [1:0]  w_beat;
    logic [31:0] w_data;
    logic        r_en;
    logic [2:0]  r_layer;
    logic [2:0]  r_addr;
    logic [1:0]  r_beat;
    logic [15:0] r_data;
    logic        r_vld;
    logic        clr_req;
    logic [2:0]  clr_layer;
    logic        busy;
    logic        err;

    int checks = 0;
    int failures = 0;

    scan_beta_store #(.P(4), .Q(4), .N(32)) dut (
        .clk(clk), .rst(rst),
        .w_en(w_en), .w_layer(w_layer), .w_addr(w_addr), .w_beat(w_beat), .w_data(w_data),
        .r_en(r_en), .r_layer(r_layer), .r_addr(r_addr), .r_beat(r_beat),
        .r_data(r_data), .r_vld(r_vld),
        .clr_req(clr_req), .clr_layer(clr_layer), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pk(int v0, int v1, int v2, int v3);
        return {4'(v3), 4'(v2), 4'(v1), 4'(v0)};
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        w_en = 0; w_layer = 0; w_addr = 0; w_beat = 0; w_data = 0;
        r_en = 0; r_layer = 0; r_addr = 0; r_beat = 0;
        clr_req = 0; clr_layer = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input int l, input int a, input int b, input logic [31:0] d);
        w_en = 1; w_layer = 3'(l); w_addr = 3'(a); w_beat = 2'(b); w_data = d;
        @(posedge clk); #1;
        w_en = 0;
    endtask

    task automatic do_read(input int l, input int a, input int b);
        r_en = 1; r_layer = 3'(l); r_addr = 3'(a); r_beat = 2'(b);
        @(posedge clk); #1;
        r_en = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (r_data !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", r_data); end
        checks++; if (r_vld !== 1'b0) begin failures++; $display("FAIL reset_rvld got=%b exp=0", r_vld); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    endtask

    task automatic test_layer2();
        do_write(2, 3, 0, {pk(3, 4, 0, 0), pk(1, 2, 0, 0)});
        do_read(2, 3, 0);
        checks++; if (r_vld !== 1'b1) begin failures++; $display("FAIL l2_vld got=%b exp=1", r_vld); end
        checks++; if (r_data !== pk(1, 2, 3, 4)) begin failures++; $display("FAIL l2_data got=%h exp=%h", r_data, pk(1, 2, 3, 4)); end
        @(posedge clk); #1;
        checks++; if (r_vld !== 1'b0 || r_data !== 16'h0) begin failures++; $display("FAIL l2_idle got=%b/%h exp=0/0", r_vld, r_data); end
    endtask

    task automatic test_multibeat();
        do_write(4, 0, 0, {pk(8, 9, 10, 11), pk(0, 1, 2, 3)});
        do_write(4, 0, 1, {pk(12, 13, 14, 15), pk(4, 5, 6, 7)});
        r_en = 1; r_layer = 3'd4; r_addr = 3'd0;
        for (int k = 0; k < 4; k++) begin
            r_beat = 2'(k);
            @(posedge clk); #1;
            checks++;
            if (r_vld !== 1'b1 || r_data !== pk(4*k, 4*k+1, 4*k+2, 4*k+3)) begin
                failures++;
                $display("FAIL l4_beat%0d got=%b/%h exp=1/%h", k, r_vld, r_data, pk(4*k, 4*k+1, 4*k+2, 4*k+3));
            end
        end
        r_en = 0;
    endtask

    task automatic test_layer1();
        do_write(1, 7, 0, {pk(9, 7, 7, 7), pk(5, 7, 7, 7)});
        do_read(1, 7, 0);
        checks++; if (r_vld !== 1'b1 || r_data !== pk(5, 9, 0, 0)) begin failures++; $display("FAIL l1_data got=%b/%h exp=1/%h", r_vld, r_data, pk(5, 9, 0, 0)); end
        do_read(1, 6, 0);
        checks++; if (r_data !== 16'h0) begin failures++; $display("FAIL l1_neighbour got=%h exp=0", r_data); end
    endtask

    task automatic test_back_to_back();
        do_write(2, 0, 0, {pk(1, 1, 0, 0), pk(1, 1, 0, 0)});
        w_en = 1; w_layer = 3'd2; w_addr = 3'd0; w_beat = 2'd0; w_data = {pk(2, 2, 0, 0), pk(2, 2, 0, 0)};
        r_en = 1; r_layer = 3'd2; r_addr = 3'd0; r_beat = 2'd0;
        @(posedge clk); #1;
        w_en = 0;
        checks++; if (r_data !== pk(1, 1, 1, 1)) begin failures++; $display("FAIL rbw_old got=%h exp=%h", r_data, pk(1, 1, 1, 1)); end
        @(posedge clk); #1;
        r_en = 0;
        checks++; if (r_data !== pk(2, 2, 2, 2)) begin failures++; $display("FAIL rbw_new got=%h exp=%h", r_data, pk(2, 2, 2, 2)); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL legal_no_err got=%b exp=0", err); end
    endtask

    task automatic test_illegal();
        do_read(3, 2, 0);
        checks++; if (r_vld !== 1'b0 || r_data !== 16'h0) begin failures++; $display("FAIL ill_addr_rd got=%b/%h exp=0/0", r_vld, r_data); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", err); end
        do_write(4, 0, 2, 32'hFFFF_FFFF);
        do_read(4, 0, 0);
        checks++; if (r_data !== pk(0, 1, 2, 3)) begin failures++; $display("FAIL ill_wr_b0 got=%h exp=%h", r_data, pk(0, 1, 2, 3)); end
        do_read(4, 0, 3);
        checks++; if (r_data !== pk(12, 13, 14, 15)) begin failures++; $display("FAIL ill_wr_b3 got=%h exp=%h", r_data, pk(12, 13, 14, 15)); end
        do_read(5, 0, 0);
        checks++; if (r_vld !== 1'b0) begin failures++; $display("FAIL ill_layer5 got=%b exp=0", r_vld); end
        do_read(2, 0, 1);
        checks++; if (r_vld !== 1'b0) begin failures++; $display("FAIL ill_rbeat got=%b exp=0", r_vld); end
    endtask

    task automatic test_clear();
        int c;
        apply_reset();
        do_write(1, 7, 0, {pk(9, 0, 0, 0), pk(5, 0, 0, 0)});
        do_write(1, 0, 0, {pk(3, 0, 0, 0), pk(6, 0, 0, 0)});
        do_write(2, 3, 0, {pk(3, 4, 0, 0), pk(1, 2, 0, 0)});
        clr_req = 1; clr_layer = 3'd1;
        @(posedge clk); #1;
        clr_req = 0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL clr_start_err got=%b exp=0", err); end
        c = 0;
        r_en = 1; r_layer = 3'd1; r_addr = 3'd7; r_beat = 2'd0;
        while (busy && c < 20) begin
            c++;
            @(posedge clk); #1;
            r_en = 0;
            if (c == 1) begin
                checks++; if (r_vld !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL clr_rd_drop got=%b/%b exp=0/1", r_vld, err); end
            end
        end
        checks++; if (c != 8) begin failures++; $display("FAIL clr_busy_cycles got=%0d exp=8", c); end
        do_read(1, 7, 0);
        checks++; if (r_vld !== 1'b1 || r_data !== 16'h0) begin failures++; $display("FAIL clr_l1a7 got=%b/%h exp=1/0", r_vld, r_data); end
        do_read(1, 0, 0);
        checks++; if (r_data !== 16'h0) begin failures++; $display("FAIL clr_l1a0 got=%h exp=0", r_data); end
        do_read(2, 3, 0);
        checks++; if (r_data !== pk(1, 2, 3, 4)) begin failures++; $display("FAIL clr_other_layer got=%h exp=%h", r_data, pk(1, 2, 3, 4)); end
    endtask

    task automatic test_reset_mid_clear();
        apply_reset();
        do_write(4, 0, 0, {pk(8, 9, 10, 11), pk(1, 2, 3, 4)});
        do_write(2, 3, 0, {pk(3, 4, 0, 0), pk(1, 2, 0, 0)});
        do_read(2, 3, 0);
        clr_req = 1; clr_layer = 3'd1;
        @(posedge clk); #1;
        clr_req = 0;
        r_en = 1; r_layer = 3'd2; r_addr = 3'd3; r_beat = 2'd0;
        @(posedge clk); #1;
        r_en = 0;
        checks++; if (busy !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b/%b exp=1/1", busy, err); end
        #2 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || r_vld !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL mid_async got=%b/%b/%b exp=0/0/0", busy, r_vld, err); end
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        do_read(2, 3, 0);
        checks++; if (r_vld !== 1'b1 || r_data !== 16'h0) begin failures++; $display("FAIL mid_l2 got=%b/%h exp=1/0", r_vld, r_data); end
        do_read(4, 0, 0);
        checks++; if (r_data !== 16'h0) begin failures++; $display("FAIL mid_l4 got=%h exp=0", r_data); end
    endtask

    initial begin
        test_reset();
        test_layer2();
        test_multibeat();
        test_layer1();
        test_back_to_back();
        test_illegal();
        test_clear();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
